hack_control_unit: RTL and testbench

- Multi-cycle sequencer/decoder for the HACK CPU.
- Fetches 16-bit instructions from ROM and decodes A- and C-instructions.
- Drives the six ALU control bits and operands, then consumes the ALU result and flags.
- Owns the A, D and PC registers and performs M reads/writes over a req/ack data-memory handshake. It sits between instruction ROM, data RAM and the combinational ALU.

---
 rtl/hack_control_unit.sv | 166 ++++++++++++++++
 tb/tb_hack_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hack_control_unit
// Purpose  : Multi-cycle fetch/decode/execute sequencer for the HACK CPU,
//            owning A, D and PC and a req/ack data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module hack_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_req,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic [15:0] ir_q;
    logic [15:0] r_q;
    logic        zr_q;
    logic        ng_q;
    logic        ram_req_q;
    logic        ram_we_q;
    logic [14:0] ram_addr_q;
    logic [15:0] ram_wdata_q;
    logic [15:0] alu_x_q;
    logic [15:0] alu_y_q;
    logic [5:0]  alu_ctrl_q;

    logic [15:0] w_res;
    logic        w_zr;
    logic        w_ng;
    logic        w_jump;
    logic        unused_ir;

    // Commit from EXEC uses the live ALU result; from MEM_WR the captured copy.
    assign w_res  = (state_q == S_EXEC) ? alu_out : r_q;
    assign w_zr   = (state_q == S_EXEC) ? alu_zr  : zr_q;
    assign w_ng   = (state_q == S_EXEC) ? alu_ng  : ng_q;
    assign w_jump = (ir_q[2] & w_ng) | (ir_q[1] & w_zr) | (ir_q[0] & ~w_zr & ~w_ng);

    assign unused_ir = ^ir_q[15:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            ir_q        <= '0;
            r_q         <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_ctrl_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q <= rom_data;
                    if (!rom_data[15]) begin
                        a_q     <= rom_data;
                        pc_q    <= pc_q + 16'd1;
                        state_q <= S_FETCH;
                    end else if (rom_data[12]) begin
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= 1'b0;
                        ram_addr_q <= a_q[14:0];
                        state_q    <= S_MEM_RD;
                    end else begin
                        alu_x_q    <= d_q;
                        alu_y_q    <= a_q;
                        alu_ctrl_q <= rom_data[11:6];
                        state_q    <= S_EXEC;
                    end
                end
                S_MEM_RD: begin
                    if (ram_ack) begin
                        ram_req_q  <= 1'b0;
                        alu_x_q    <= d_q;
                        alu_y_q    <= ram_rdata;
                        alu_ctrl_q <= ir_q[11:6];
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_q        <= alu_out;
                    zr_q       <= alu_zr;
                    ng_q       <= alu_ng;
                    alu_x_q    <= '0;
                    alu_y_q    <= '0;
                    alu_ctrl_q <= '0;
                    if (ir_q[3]) begin
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= a_q[14:0];
                        ram_wdata_q <= alu_out;
                        state_q     <= S_MEM_WR;
                    end else begin
                        if (ir_q[5]) a_q <= w_res;
                        if (ir_q[4]) d_q <= w_res;
                        pc_q    <= w_jump ? a_q : pc_q + 16'd1;
                        state_q <= S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    if (ram_ack) begin
                        ram_req_q <= 1'b0;
                        ram_we_q  <= 1'b0;
                        if (ir_q[5]) a_q <= w_res;
                        if (ir_q[4]) d_q <= w_res;
                        pc_q    <= w_jump ? a_q : pc_q + 16'd1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign rom_addr  = pc_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_control_unit
// Purpose  : Table-driven bench for hack_control_unit with ROM, RAM and ALU
//            models and result/memory-access scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_req;
    logic        ram_ack;
    logic [15:0] ram_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_reg;
    logic [15:0] d_reg;

    hack_control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_req   (ram_req),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_zx    (alu_zx),
        .alu_nx    (alu_nx),
        .alu_zy    (alu_zy),
        .alu_ny    (alu_ny),
        .alu_f     (alu_f),
        .alu_no    (alu_no),
        .alu_out   (alu_out),
        .alu_zr    (alu_zr),
        .alu_ng    (alu_ng),
        .a_reg     (a_reg),
        .d_reg     (d_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // HACK ALU reference
    logic [15:0] m_x1, m_x2, m_y1, m_y2, m_o;
    always_comb begin
        m_x1    = alu_zx ? 16'h0000 : alu_x;
        m_x2    = alu_nx ? ~m_x1 : m_x1;
        m_y1    = alu_zy ? 16'h0000 : alu_y;
        m_y2    = alu_ny ? ~m_y1 : m_y1;
        m_o     = alu_f ? (m_x2 + m_y2) : (m_x2 & m_y2);
        alu_out = alu_no ? ~m_o : m_o;
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    logic [15:0] rom [0:65535];
    logic [15:0] ram [0:32767];
    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) if (ram_req && ram_we && ram_ack) ram[ram_addr] <= ram_wdata;

    typedef struct {
        bit          we;
        logic [14:0] addr;
        logic [15:0] wdata;
        int          wt;
    } mem_t;

    mem_t mq[$];
    bit   spurious = 1'b0;
    int   req_cnt  = 0;

    // RAM responder: checks each request cycle against the expected access.
    always @(negedge clk) begin
        if (ram_req) begin
            if (mq.size() == 0) begin
                chk("ram_unexpected_req", 32'(ram_req), 32'd0);
                ram_ack = 1'b0;
            end else begin
                chk("ram_we", 32'(ram_we), 32'(mq[0].we));
                chk("ram_addr", 32'(ram_addr), 32'(mq[0].addr));
                if (mq[0].we) chk("ram_wdata", 32'(ram_wdata), 32'(mq[0].wdata));
                if (req_cnt == mq[0].wt) begin
                    ram_ack   = 1'b1;
                    ram_rdata = ram[ram_addr];
                    req_cnt   = 0;
                    void'(mq.pop_front());
                end else begin
                    ram_ack = 1'b0;
                    req_cnt++;
                end
            end
        end else begin
            ram_ack   = spurious;
            ram_rdata = 16'hDEAD;
            req_cnt   = 0;
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        int          cyc;
        int          ex;
        logic [5:0]  ctrl;
        logic [15:0] x, y, a, d, npc;
        bit          rd;
        int          rdw;
        bit          wr;
        int          wrw;
        logic [14:0] maddr;
        logic [15:0] wdata;
        bit          spur;
    } vec_t;

    typedef struct {
        logic [15:0] a, d, pc;
    } exp_t;

    exp_t expq[$];
    vec_t vt[17];

    function automatic vec_t mkv(input logic [15:0] pc, input logic [15:0] instr, input int cyc,
                                 input int ex, input logic [5:0] ctrl, input logic [15:0] x,
                                 input logic [15:0] y, input logic [15:0] a, input logic [15:0] d,
                                 input logic [15:0] npc);
        vec_t v;
        v.pc = pc; v.instr = instr; v.cyc = cyc; v.ex = ex; v.ctrl = ctrl;
        v.x = x; v.y = y; v.a = a; v.d = d; v.npc = npc;
        v.rd = 1'b0; v.rdw = 0; v.wr = 1'b0; v.wrw = 0;
        v.maddr = '0; v.wdata = '0; v.spur = 1'b0;
        return v;
    endfunction

    task automatic chk_alu_idle(input string name);
        chk(name, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        spurious = v.spur;
        if (v.rd) mq.push_back('{1'b0, v.maddr, 16'h0000, v.rdw});
        if (v.wr) mq.push_back('{1'b1, v.maddr, v.wdata, v.wrw});
        expq.push_back('{v.a, v.d, v.npc});
        chk("pc_start", 32'(rom_addr), 32'(v.pc));
        for (int k = 1; k <= v.cyc; k++) begin
            @(negedge clk);
            if (k == v.ex) begin
                chk("alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(v.ctrl));
                chk("alu_x", 32'(alu_x), 32'(v.x));
                chk("alu_y", 32'(alu_y), 32'(v.y));
            end else begin
                chk_alu_idle("alu_idle");
            end
            @(posedge clk);
        end
        #1;
        e = expq.pop_front();
        chk("a_reg", 32'(a_reg), 32'(e.a));
        chk("d_reg", 32'(d_reg), 32'(e.d));
        chk("pc_next", 32'(rom_addr), 32'(e.pc));
        chk("req_idle", 32'(ram_req), 32'd0);
        chk("mem_drained", 32'(mq.size()), 32'd0);
        spurious = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n   = 1'b0;
        ram_ack = 1'b0;
        ram_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;

        vt[0]  = mkv(16'h0000, 16'h0005, 2, 0, 6'b000000, 16'h0, 16'h0, 16'h0005, 16'h0000, 16'h0001);
        vt[1]  = mkv(16'h0001, 16'hEC10, 3, 3, 6'b110000, 16'h0, 16'h5, 16'h0005, 16'h0005, 16'h0002);
        vt[1].spur = 1'b1;
        vt[2]  = mkv(16'h0002, 16'hE7C8, 6, 3, 6'b011111, 16'h5, 16'h5, 16'h0005, 16'h0005, 16'h0003);
        vt[2].wr = 1'b1; vt[2].wrw = 2; vt[2].maddr = 15'd5; vt[2].wdata = 16'h0006;
        vt[3]  = mkv(16'h0003, 16'hFC10, 5, 5, 6'b110000, 16'h5, 16'h6, 16'h0005, 16'h0006, 16'h0004);
        vt[3].rd = 1'b1; vt[3].rdw = 1; vt[3].maddr = 15'd5; vt[3].spur = 1'b1;
        vt[4]  = mkv(16'h0004, 16'hFDC8, 5, 4, 6'b110111, 16'h6, 16'h6, 16'h0005, 16'h0006, 16'h0005);
        vt[4].rd = 1'b1; vt[4].wr = 1'b1; vt[4].maddr = 15'd5; vt[4].wdata = 16'h0007;
        vt[5]  = mkv(16'h0005, 16'h0010, 2, 0, 6'b000000, 16'h0, 16'h0, 16'h0010, 16'h0006, 16'h0006);
        vt[6]  = mkv(16'h0006, 16'hE301, 3, 3, 6'b001100, 16'h6, 16'h10, 16'h0010, 16'h0006, 16'h0010);
        vt[7]  = mkv(16'h0010, 16'hE302, 3, 3, 6'b001100, 16'h6, 16'h10, 16'h0010, 16'h0006, 16'h0011);
        vt[8]  = mkv(16'h0011, 16'hEA90, 3, 3, 6'b101010, 16'h6, 16'h10, 16'h0010, 16'h0000, 16'h0012);
        vt[9]  = mkv(16'h0012, 16'h0020, 2, 0, 6'b000000, 16'h0, 16'h0, 16'h0020, 16'h0000, 16'h0013);
        vt[10] = mkv(16'h0013, 16'hE302, 3, 3, 6'b001100, 16'h0, 16'h20, 16'h0020, 16'h0000, 16'h0020);
        vt[11] = mkv(16'h0020, 16'hEDF7, 3, 3, 6'b110111, 16'h0, 16'h20, 16'h0021, 16'h0021, 16'h0020);
        vt[12] = mkv(16'h0020, 16'hEDF7, 3, 3, 6'b110111, 16'h21, 16'h21, 16'h0022, 16'h0022, 16'h0021);
        vt[13] = mkv(16'h0021, 16'hEEA0, 3, 3, 6'b111010, 16'h22, 16'h22, 16'hFFFF, 16'h0022, 16'h0022);
        vt[14] = mkv(16'h0022, 16'hEA87, 3, 3, 6'b101010, 16'h22, 16'hFFFF, 16'hFFFF, 16'h0022, 16'hFFFF);
        vt[15] = mkv(16'hFFFF, 16'h0003, 2, 0, 6'b000000, 16'h0, 16'h0, 16'h0003, 16'h0022, 16'h0000);
        vt[16] = mkv(16'h0000, 16'h0005, 2, 0, 6'b000000, 16'h0, 16'h0, 16'h0005, 16'h0022, 16'h0001);
        foreach (vt[i]) rom[vt[i].pc] = vt[i].instr;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_a_reg", 32'(a_reg), 32'd0);
        chk("rst_d_reg", 32'(d_reg), 32'd0);
        chk("rst_ram_req", 32'({ram_req, ram_we}), 32'd0);
        chk_alu_idle("rst_alu_idle");
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Reset during a stalled write: outputs must drop without a clock edge.
        v = mkv(16'h0001, 16'hEC10, 3, 3, 6'b110000, 16'h22, 16'h5, 16'h0005, 16'h0005, 16'h0002);
        run_vec(v);
        mq.push_back('{1'b1, 15'd5, 16'h0006, 100});
        chk("mr_pc_start", 32'(rom_addr), 32'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mr_req_high", 32'({ram_req, ram_we}), 32'd3);
        chk("mr_addr", 32'(ram_addr), 32'd5);
        chk("mr_wdata", 32'(ram_wdata), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_req_drop", 32'({ram_req, ram_we}), 32'd0);
        chk("mr_pc", 32'(rom_addr), 32'd0);
        chk("mr_regs", 32'({a_reg, d_reg}), 32'd0);
        chk_alu_idle("mr_alu_idle");
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("mr_hold", 32'({ram_req, rom_addr}), 32'd0);
        rst_n = 1'b1;
        v = vt[0];
        run_vec(v);
        chk("mr_ram_untouched", 32'(ram[5]), 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
